hazard_stall_ctrl: RTL and testbench

//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage core.
//  - Load-use hazard -> inserts a one-cycle bubble into ID/EX.
//  - Taken branch/jump -> flushes IF/ID.
//  - Busy data memory -> freezes the whole front pipeline through a wait FSM,

---
 rtl/hazard_stall_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing for the 5-stage core: load-use bubble, branch flush, and a
// memory-wait freeze FSM with watchdog, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WAIT_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               lu;
    logic               freeze;
    logic               hazard_ok;

    assign lu = idex_memread_i && (idex_rt_i != 5'd0)
                && ((idex_rt_i == ifid_rs_i)
                    || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // freeze: every enable low; hazard_ok: the lu/branch rules decide the outputs.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        freeze    = 1'b0;
        hazard_ok = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    hazard_ok = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    hazard_ok = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) state_d = ERR;
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                freeze  = 1'b1;
                state_d = RUN;
            end
        endcase

        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        exmem_write_o = 1'b1;
        if (freeze) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
        end else if (hazard_ok && lu) begin
            // Branch is deliberately ignored here; it re-resolves after the bubble.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (hazard_ok && branch_taken_i) begin
            ifid_flush_o  = 1'b1;
        end

        // Reset fills the pipeline with NOPs regardless of state.
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_write_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_write_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_d == ERR) err_q <= 1'b1;
            if (!pc_write_o && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = cnt_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: driver pushes reference-model expectations into a
// queue each cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_stall_ctrl;
    localparam int TIMEOUT = 64;
    localparam int CNT_MAX = 65535;

    typedef struct packed {
        logic       rst;
        logic       memread;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        idex_memread_i = 1'b0;
    logic [4:0]  idex_rt_i = '0;
    logic [4:0]  ifid_rs_i = '0;
    logic [4:0]  ifid_rt_i = '0;
    logic        ifid_uses_rt_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        mem_req_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic        pc_write_o, ifid_write_o, ifid_flush_o;
    logic        idex_write_o, idex_bubble_o, exmem_write_o, err_o;
    logic [15:0] stall_cnt_o;
    logic [1:0]  state_o;

    logic [24:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    // Reference model: mode 0 running, 1 waiting on memory, 2 error.
    int m_mode = 0;
    int m_frozen = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    hazard_stall_ctrl #(.CNT_W(16), .WAIT_W(8), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .ifid_uses_rt_i(ifid_uses_rt_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_write_o(idex_write_o), .idex_bubble_o(idex_bubble_o),
        .exmem_write_o(exmem_write_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o),
        .state_o(state_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Driver: applies one cycle of stimulus and queues the model's expectation.
    // Expected vector: {state, pc, ifid_w, flush, idex_w, bubble, exmem_w, err, cnt}.
    task automatic step(input stim_t s);
        logic [5:0] o;
        bit         lu;
        bit         decide;
        int         mode_n;
        @(posedge clk_i);
        #1;
        rst_i = s.rst; idex_memread_i = s.memread; idex_rt_i = s.idex_rt;
        ifid_rs_i = s.rs; ifid_rt_i = s.rt; ifid_uses_rt_i = s.uses;
        branch_taken_i = s.br; mem_req_i = s.req; mem_ready_i = s.rdy;

        lu = s.memread && (s.idex_rt != 0)
             && ((s.idex_rt == s.rs) || (s.uses && (s.idex_rt == s.rt)));
        mode_n = m_mode;
        decide = 1'b0;
        o = 6'b000000;
        if (s.rst) begin
            o = 6'b001111;
        end else if (m_mode == 0) begin
            if (s.req && !s.rdy) begin
                mode_n = 1;
                m_frozen = 1;
            end else begin
                decide = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (s.rdy) begin
                mode_n = 0;
                m_frozen = 0;
                decide = 1'b1;
            end else begin
                m_frozen++;
                if (m_frozen == TIMEOUT) mode_n = 2;
            end
        end
        if (decide) begin
            if (lu)        o = 6'b000111;
            else if (s.br) o = 6'b111101;
            else           o = 6'b110101;
        end

        exp_q.push_back({2'(m_mode), o, m_err, 16'(m_cnt)});

        if (s.rst) begin
            m_mode = 0; m_frozen = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            if (!o[5] && m_cnt < CNT_MAX) m_cnt++;
            m_mode = mode_n;
            if (mode_n == 2) m_err = 1'b1;
        end
    endtask

    task automatic repeat_step(input stim_t s, input int n);
        for (int i = 0; i < n; i++) step(s);
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        logic [24:0] act;
        logic [24:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act = {state_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                   idex_bubble_o, exmem_write_o, err_o, stall_cnt_o};
            n_checks++;
            if (act !== exp_v) begin
                n_errors++;
                $display("FAIL outputs cyc %0d got %h exp %h", cyc, act, exp_v);
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        // Let reset settle registered state before checking begins.
        @(posedge clk_i);
        @(posedge clk_i);

        // Reset held three cycles, then idle.
        s = idle(); s.rst = 1'b1;
        repeat_step(s, 3);
        repeat_step(idle(), 2);

        // Load-use on rs, then idle; same with rt=0 (no hazard); then rt-source hazard.
        s = idle(); s.memread = 1'b1; s.idex_rt = 5'd5; s.rs = 5'd5;
        step(s);
        step(idle());
        s.idex_rt = 5'd0; s.rs = 5'd0;
        step(s);
        s = idle(); s.memread = 1'b1; s.idex_rt = 5'd7; s.rt = 5'd7; s.uses = 1'b1;
        step(s);
        s.uses = 1'b0;
        step(s);

        // Load-use together with branch, then branch alone.
        s = idle(); s.memread = 1'b1; s.idex_rt = 5'd3; s.rs = 5'd3; s.br = 1'b1;
        step(s);
        s = idle(); s.br = 1'b1;
        step(s);

        // Memory wait of four cycles, completing with a branch taken.
        s = idle(); s.req = 1'b1;
        repeat_step(s, 4);
        s.rdy = 1'b1; s.br = 1'b1;
        step(s);
        repeat_step(idle(), 2);

        // Watchdog timeout, stays in error, reset clears it.
        s = idle(); s.req = 1'b1;
        repeat_step(s, TIMEOUT + 6);
        s = idle(); s.rdy = 1'b1;
        repeat_step(s, 2);
        s = idle(); s.rst = 1'b1;
        repeat_step(s, 2);
        repeat_step(idle(), 2);

        // Randomized traffic with a stable memory handshake.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.memread = 1'($urandom_range(0, 1));
            s.idex_rt = 5'($urandom_range(0, 3));
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.uses    = 1'($urandom_range(0, 1));
            s.br      = 1'($urandom_range(0, 2) == 0);
            if (m_mode == 1) begin
                s.req = 1'b1;
                s.rdy = 1'($urandom_range(0, 2) == 0);
            end else begin
                s.req = 1'($urandom_range(0, 3) == 0);
                s.rdy = 1'($urandom_range(0, 1));
            end
            s.rst = 1'($urandom_range(0, 199) == 0);
            step(s);
        end

        // Stall counter saturation: freeze long enough to pass 0xFFFF.
        s = idle(); s.rst = 1'b1;
        step(s);
        s = idle(); s.req = 1'b1;
        repeat_step(s, CNT_MAX + 5);
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());

        @(negedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
